// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: FSM state codes and a width helper.
package cpu_run_ctrl_pkg;

   typedef enum logic [1:0] {
      RC_RST  = 2'd0,
      RC_RUN  = 2'd1,
      RC_DONE = 2'd2
   } rc_state_t;

   // Bits needed to hold the value n (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_halt_detector.sv
// Per-core halt detector: flags a core whose valid PC samples repeat HALT_REPEAT times in a row.
module halt_detector
   import cpu_run_ctrl_pkg::*;
#(
   parameter int unsigned PC_W        = 32,
   parameter int unsigned HALT_REPEAT = 8
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            en,
   input  logic [PC_W-1:0] pc,
   input  logic            pc_valid,
   output logic            halted,
   output logic            halt_set
);

   localparam int unsigned RCW = cnt_w(HALT_REPEAT);
   localparam logic [RCW-1:0] REP_LAST = RCW'(HALT_REPEAT - 1);
   localparam logic [RCW-1:0] REP_MAX  = RCW'(HALT_REPEAT);

   logic [PC_W-1:0] last_pc;
   logic [RCW-1:0]  rep_cnt;
   logic            seen;
   logic            same;

   // The seen flag makes the first valid sample a "differs" regardless of last_pc.
   assign same     = seen && (pc == last_pc);
   assign halt_set = en && pc_valid && same && (rep_cnt == REP_LAST);

   always_ff @(posedge clk) begin
      if (clr) begin
         last_pc <= '0;
         rep_cnt <= '0;
         seen    <= 1'b0;
         halted  <= 1'b0;
      end else if (en && pc_valid) begin
         seen <= 1'b1;
         if (!same) begin
            last_pc <= pc;
            rep_cnt <= RCW'(1);
         end else if (rep_cnt != REP_MAX) begin
            rep_cnt <= rep_cnt + RCW'(1);
         end
         if (halt_set) halted <= 1'b1;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: reset sequencing, run-cycle budget and all-cores-halted detection.
// Optional simulation trace/auto-finish enabled by defining RUN_CTRL_TRACE_EN.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int unsigned NCH          = 1,
   parameter int unsigned PC_W         = 32,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned HALT_REPEAT  = 8,
   parameter int unsigned MAX_CYCLES   = 10000
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [NCH*PC_W-1:0] pc,
   input  logic [NCH-1:0]      pc_valid,
   output logic                cpu_clr,
   output logic                running,
   output logic                done,
   output logic                timeout,
   output logic [NCH-1:0]      halted,
   output logic [CNT_W-1:0]    cycle_cnt
);

   localparam int unsigned RW = cnt_w(RESET_CYCLES);
   localparam logic [RW-1:0]    RST_LAST = RW'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

   rc_state_t      state;
   logic [RW-1:0]  rst_cnt;
   logic [NCH-1:0] halt_set;
   logic           run_en;
   logic           all_halt;

   assign run_en   = (state == RC_RUN);
   // Halts landing on this edge count towards the all-halted exit.
   assign all_halt = &(halted | halt_set);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      halt_detector #(
         .PC_W        (PC_W),
         .HALT_REPEAT (HALT_REPEAT)
      ) u_hd (
         .clk      (clk),
         .clr      (clr),
         .en       (run_en),
         .pc       (pc[g*PC_W +: PC_W]),
         .pc_valid (pc_valid[g]),
         .halted   (halted[g]),
         .halt_set (halt_set[g])
      );
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= RC_RST;
         rst_cnt   <= '0;
         cpu_clr   <= 1'b1;
         running   <= 1'b0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         case (state)
            RC_RST: begin
               cpu_clr <= 1'b1;
               running <= 1'b0;
               if (rst_cnt == RST_LAST) begin
                  state   <= RC_RUN;
                  rst_cnt <= '0;
                  cpu_clr <= 1'b0;
                  running <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + RW'(1);
               end
            end
            RC_RUN: begin
               // Saturates at the budget limit so the counter never wraps.
               if (cycle_cnt != CNT_LAST) cycle_cnt <= cycle_cnt + CNT_W'(1);
               if (all_halt) begin
                  state   <= RC_DONE;
                  done    <= 1'b1;
                  timeout <= 1'b0;
                  running <= 1'b0;
                  cpu_clr <= 1'b1;
               end else if (cycle_cnt == CNT_LAST) begin
                  state   <= RC_DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
                  running <= 1'b0;
                  cpu_clr <= 1'b1;
               end
            end
            RC_DONE: begin
               running <= 1'b0;
               cpu_clr <= 1'b1;
            end
            default: begin
               state   <= RC_RST;
               rst_cnt <= '0;
               cpu_clr <= 1'b1;
               running <= 1'b0;
            end
         endcase
      end
   end

`ifdef RUN_CTRL_TRACE_EN
   logic [NCH-1:0] halted_d;
   logic           done_d;

   always @(posedge clk) begin
      for (int unsigned i = 0; i < NCH; i++) begin
         if (halted[i] && !halted_d[i])
            $display("core %0d halted pc=%h cyc=%0d", i, pc[i*PC_W +: PC_W], cycle_cnt);
      end
      if (done && !done_d)
         $display("run done: cyc=%0d timeout=%0b halted=%b", cycle_cnt, timeout, halted);
      if (done && done_d) $finish;
      halted_d <= clr ? '0 : halted;
      done_d   <= clr ? 1'b0 : done;
   end
`endif

endmodule
